stopwatch_lap_core: RTL and testbench

Parametrised stopwatch core: MM:SS.cc timebase with a run/stop/clear state machine, a circular lap buffer with recall, and per-digit 7-segment outputs.
Successor to the fixed-rate stopwatch top. Adds a configurable tick divider, minute range, lap capture and review, overflow flags, and selectable segment polarity.
Sits between the debounced board buttons and the six-digit display.

---
 rtl/stopwatch_pkg.sv | 31 +++
 rtl/bcd_digit_cnt.sv | 20 ++
 rtl/stopwatch_lap_core.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_lap_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch core: FSM states, BCD time record,
// button event priority and the 7-segment digit table.
package stopwatch_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_VIEW} sw_state_e;

  typedef struct packed {
    logic [3:0] m10, m1, s10, s1, c10, c1;
  } bcd_time_t;

  // Highest priority first: clear, start_stop, lap
  typedef enum logic [1:0] {EV_NONE, EV_CLEAR, EV_START, EV_LAP} btn_evt_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  // gfedcba, index 0 in the low slot
  localparam logic [9:0][6:0] SEG_TBL = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                         7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

  function automatic btn_evt_e pick_event(input logic c, input logic s, input logic l);
    if (c) return EV_CLEAR;
    if (s) return EV_START;
    if (l) return EV_LAP;
    return EV_NONE;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_TBL[d];
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit 0..MAX_DIGIT; carry is combinational so ripples on the same edge.
module bcd_digit_cnt #(
  parameter int MAX_DIGIT = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry
);
  assign carry = inc && (digit == 4'(MAX_DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             digit <= '0;
    else if (clr)        digit <= '0;
    else if (carry)      digit <= '0;
    else if (inc)        digit <= digit + 4'd1;
  end
endmodule

// File: rtl/stopwatch_lap_core.sv
// MM:SS.cc stopwatch with run/stop/clear FSM, circular lap buffer with
// recall, and combinational per-digit 7-segment outputs.
module stopwatch_lap_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV       = 500000,
  parameter int MIN_MAX        = 99,
  parameter int LAP_DEPTH      = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_stop,
  input  logic                           lap,
  input  logic                           clear,
  output logic                           running,
  output logic                           view_mode,
  output logic [$clog2(LAP_DEPTH)-1:0]   lap_idx,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           ovf,
  output logic                           lap_ovf,
  output logic [23:0]                    disp_bcd,
  output logic [6:0]                     seg5,
  output logic [6:0]                     seg4,
  output logic [6:0]                     seg3,
  output logic [6:0]                     seg2,
  output logic [6:0]                     seg1,
  output logic [6:0]                     seg0
);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH+1);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [6:0] POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  sw_state_e state_q, state_d;
  logic [2:0] btn, btn_prev, rise;
  btn_evt_e   evt;
  logic       lap_wr, clr_all, view_enter, idx_step, tick, wrap;
  logic [DW-1:0] div_q;
  logic [5:0][3:0] dig;
  bcd_time_t  tm;
  bcd_time_t  lap_buf [LAP_DEPTH];
  logic [AW-1:0] wr_ptr, rd_addr;
  logic [5:0][6:0] segs;

  // Prev resets high so a button held through reset needs a release first
  assign btn  = {clear, start_stop, lap};
  assign rise = btn & ~btn_prev;
  assign evt  = pick_event(rise[2], rise[1], rise[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev <= '1;
      state_q  <= S_IDLE;
    end else begin
      btn_prev <= btn;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lap_wr     = 1'b0;
    clr_all    = 1'b0;
    view_enter = 1'b0;
    idx_step   = 1'b0;
    case (state_q)
      S_IDLE: if (evt == EV_START) state_d = S_RUN;
      S_RUN: begin
        if (evt == EV_START)    state_d = S_STOP;
        else if (evt == EV_LAP) lap_wr = 1'b1;
      end
      S_STOP: begin
        if (evt == EV_CLEAR) begin
          state_d = S_IDLE;
          clr_all = 1'b1;
        end else if (evt == EV_START) begin
          state_d = S_RUN;
        end else if (evt == EV_LAP && lap_count != '0) begin
          state_d    = S_VIEW;
          view_enter = 1'b1;
        end
      end
      S_VIEW: begin
        if (evt == EV_CLEAR || evt == EV_START) state_d = S_STOP;
        else if (evt == EV_LAP)                 idx_step = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divider holds outside RUN so resume keeps phase
  assign tick = (state_q == S_RUN) && (div_q == DW'(TICK_DIV-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 div_q <= '0;
    else if (state_q == S_IDLE || clr_all)   div_q <= '0;
    else if (state_q == S_RUN)               div_q <= tick ? '0 : div_q + DW'(1);
  end

  for (genvar i = 0; i < 6; i++) begin : g_dig
    localparam int MX = (i == 5) ? MIN_MAX/10 : (i == 3) ? 5 : 9;
    logic inc_i, cy_i;
    if (i == 0) begin : g_lsb
      assign inc_i = tick;
    end else begin : g_up
      assign inc_i = g_dig[i-1].cy_i;
    end
    bcd_digit_cnt #(.MAX_DIGIT(MX)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_i),
      .clr   ((i >= 4) ? (clr_all || wrap) : clr_all),
      .digit (dig[i]),
      .carry (cy_i)
    );
  end

  assign tm = bcd_time_t'(dig);
  // Minute field wraps at MIN_MAX, not at its natural BCD limit; m10 carry is a subset
  assign wrap = (g_dig[3].cy_i && tm.m10 == 4'(MIN_MAX/10) && tm.m1 == 4'(MIN_MAX%10))
              || g_dig[5].cy_i;

  always_ff @(posedge clk) begin
    if (lap_wr) lap_buf[wr_ptr] <= tm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      lap_count <= '0;
      lap_idx   <= '0;
      ovf       <= 1'b0;
      lap_ovf   <= 1'b0;
    end else begin
      if (clr_all) begin
        wr_ptr    <= '0;
        lap_count <= '0;
        ovf       <= 1'b0;
        lap_ovf   <= 1'b0;
      end else begin
        if (wrap) ovf <= 1'b1;
        if (lap_wr) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (lap_count == CW'(LAP_DEPTH)) lap_ovf   <= 1'b1;
          else                             lap_count <= lap_count + CW'(1);
        end
      end
      if (view_enter)
        lap_idx <= '0;
      else if (idx_step)
        lap_idx <= (CW'(lap_idx) == lap_count - CW'(1)) ? '0 : lap_idx + AW'(1);
    end
  end

  // Oldest entry sits lap_count slots behind the write pointer
  assign rd_addr   = wr_ptr - lap_count[AW-1:0] + lap_idx;
  assign disp_bcd  = (state_q == S_VIEW) ? lap_buf[rd_addr] : tm;
  assign running   = (state_q == S_RUN);
  assign view_mode = (state_q == S_VIEW);

  for (genvar i = 0; i < 6; i++) begin : g_seg
    assign segs[i] = seg7(disp_bcd[4*i +: 4]) ^ POL;
  end

  assign seg0 = segs[0];
  assign seg1 = segs[1];
  assign seg2 = segs[2];
  assign seg3 = segs[3];
  assign seg4 = segs[4];
  assign seg5 = segs[5];
endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Scoreboard bench: stimulus steps a centisecond/queue reference model and
// pushes expected outputs; a negedge monitor pops and compares.
module tb_stopwatch_lap_core;
  localparam int TD  = 4;
  localparam int MM  = 1;
  localparam int LD  = 4;
  localparam int SAL = 1;
  localparam int AW  = 2;
  localparam int CW  = 3;
  localparam int WRAP_CS = (MM + 1) * 6000;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_VIEW = 3;

  logic clk = 1'b1;
  logic rst, start_stop, lap, clear;
  logic running, view_mode, ovf, lap_ovf;
  logic [AW-1:0] lap_idx;
  logic [CW-1:0] lap_count;
  logic [23:0] disp_bcd;
  logic [6:0] seg5, seg4, seg3, seg2, seg1, seg0;

  stopwatch_lap_core #(.TICK_DIV(TD), .MIN_MAX(MM), .LAP_DEPTH(LD), .SEG_ACTIVE_LOW(SAL)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
    .running(running), .view_mode(view_mode), .lap_idx(lap_idx), .lap_count(lap_count),
    .ovf(ovf), .lap_ovf(lap_ovf), .disp_bcd(disp_bcd),
    .seg5(seg5), .seg4(seg4), .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0)
  );

  always #5 clk = ~clk;

  typedef logic [2+AW+CW+2+24+42-1:0] obs_t;
  obs_t exp_q[$];
  int vectors = 0, miscompares = 0, ncyc = 0;

  // reference model state
  int m_state, m_div, m_cs, m_idx;
  int laps[$];
  bit m_ovf, m_lovf, p_ss, p_lap, p_clr;

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m/10), 4'(m%10), 4'(s/10), 4'(s%10), 4'(c/10), 4'(c%10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0: r = 7'h3F; 4'd1: r = 7'h06; 4'd2: r = 7'h5B; 4'd3: r = 7'h4F;
      4'd4: r = 7'h66; 4'd5: r = 7'h6D; 4'd6: r = 7'h7D; 4'd7: r = 7'h07;
      4'd8: r = 7'h7F; 4'd9: r = 7'h6F; default: r = 7'h00;
    endcase
    return (SAL != 0) ? ~r : r;
  endfunction

  function automatic obs_t expected();
    logic [23:0] d;
    logic [41:0] s;
    d = (m_state == M_VIEW) ? to_bcd(laps[m_idx]) : to_bcd(m_cs);
    for (int i = 0; i < 6; i++) s[7*i +: 7] = seg_of(d[4*i +: 4]);
    return {m_state == M_RUN, m_state == M_VIEW, AW'(m_idx), CW'(laps.size()),
            m_ovf, m_lovf, d, s};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_div = 0; m_cs = 0; m_idx = 0;
    laps.delete(); m_ovf = 0; m_lovf = 0;
    p_ss = 1; p_lap = 1; p_clr = 1;
  endtask

  // One clock edge with the inputs the DUT is currently seeing
  task automatic model_edge();
    bit e_c, e_s, e_l, tk;
    int ev, cap;
    if (rst) begin model_reset(); return; end
    e_c = clear && !p_clr; e_s = start_stop && !p_ss; e_l = lap && !p_lap;
    p_clr = clear; p_ss = start_stop; p_lap = lap;
    ev = e_c ? 1 : e_s ? 2 : e_l ? 3 : 0;
    tk = (m_state == M_RUN) && (m_div == TD - 1);
    cap = m_cs;
    if (m_state == M_RUN) begin
      m_div = tk ? 0 : m_div + 1;
      if (tk) begin
        m_cs++;
        if (m_cs == WRAP_CS) begin m_cs = 0; m_ovf = 1; end
      end
    end else if (m_state == M_IDLE) m_div = 0;
    case (m_state)
      M_IDLE: if (ev == 2) m_state = M_RUN;
      M_RUN: begin
        if (ev == 2) m_state = M_STOP;
        else if (ev == 3) begin
          laps.push_back(cap);
          if (laps.size() > LD) begin void'(laps.pop_front()); m_lovf = 1; end
        end
      end
      M_STOP: begin
        if (ev == 1) begin
          m_state = M_IDLE; m_cs = 0; m_div = 0; laps.delete(); m_ovf = 0; m_lovf = 0;
        end else if (ev == 2) m_state = M_RUN;
        else if (ev == 3 && laps.size() > 0) begin m_state = M_VIEW; m_idx = 0; end
      end
      default: begin
        if (ev == 1 || ev == 2) m_state = M_STOP;
        else if (ev == 3) m_idx = (m_idx + 1) % laps.size();
      end
    endcase
  endtask

  task automatic step(input bit ss, input bit lp, input bit cl, input bit rs);
    @(posedge clk); #1;
    model_edge();
    start_stop = ss; lap = lp; clear = cl; rst = rs;
    if (rs) model_reset();
    exp_q.push_back(expected());
  endtask

  task automatic hold(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic press(input int b);
    step(b == 0, b == 1, b == 2, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic wait_cs(input int t);
    for (int k = 0; k < 2000 && m_cs < t; k++) step(0, 0, 0, 0);
  endtask

  // monitor
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      ncyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {running, view_mode, lap_idx, lap_count, ovf, lap_ovf, disp_bcd,
             seg5, seg4, seg3, seg2, seg1, seg0};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got %h expected %h", ncyc, a, e);
        end
      end
    end
  end

  initial begin
    bit ls, ll, lc;
    rst = 1; start_stop = 1; lap = 0; clear = 0;
    model_reset();
    // start_stop held across reset release gives no edge
    repeat (3) step(1, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // run one second, stop, confirm frozen
    press(0); hold(400); press(0); hold(100);
    // laps at 5/10/20 cs then review
    press(2); press(0);
    wait_cs(5);  press(1);
    wait_cs(10); press(1);
    wait_cs(20); press(1);
    press(0);
    repeat (4) begin press(1); hold(2); end
    press(0); hold(3);
    // six laps into depth-4 buffer
    press(2); press(0);
    repeat (6) begin hold(5); press(1); end
    press(0); press(1); press(1); press(2); hold(2);
    // start_stop and clear together in STOP
    step(1, 0, 1, 0); step(0, 0, 0, 0); hold(3);
    // lap edge on a tick cycle
    press(0); hold(9);
    for (int k = 0; k < 10 && m_div != TD - 1; k++) step(0, 0, 0, 0);
    lap = 1; step(0, 0, 0, 0); hold(4);
    press(0); press(1); hold(2); press(0);
    // random button activity
    ls = 0; ll = 0; lc = 0;
    repeat (3000) begin
      if ($urandom_range(7) == 0) ls = !ls;
      if ($urandom_range(5) == 0) ll = !ll;
      if ($urandom_range(15) == 0) lc = !lc;
      step(ls, ll, lc, 0);
    end
    hold(2);
    // async reset mid-RUN
    step(0, 0, 0, 1); step(0, 0, 0, 0);
    press(0); hold(57);
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 0);
    // full-range wrap sets ovf, clear from STOP drops it
    press(0); hold(WRAP_CS * TD + 20);
    press(1); press(0); press(1); press(0); press(2); hold(5);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
